fc8_line_fetch: RTL and testbench

Scanline prefetch stage sitting directly upstream of `fc8_vga`. It reads the next visible line of the 256x240 8-bit bitmap from VRAM through a request/acknowledge port while the current line is displayed. It holds the two lines in a ping-pong line buffer and presents one colour index per pixel clock on `pix_data`, which drives `fc8_vga`'s `vram_data`. Hardware scroll and underrun detection are included.

---
 rtl/fc8_line_fetch.sv | 139 +++++++++++++
 tb/tb_fc8_line_fetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc8_line_fetch.sv
// Scanline prefetch for fc8_vga: fetches the next visible line from VRAM into a
// ping-pong line buffer while the current line is shown, with scroll and underrun flag.
module fc8_line_fetch #(
    parameter int         H_ACTIVE = 256,
    parameter int         V_ACTIVE = 240,
    parameter int         V_TOTAL  = 262,
    parameter logic [7:0] FILL     = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [7:0]  scroll_x,
    input  logic [7:0]  scroll_y,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  pix_data,
    output logic        fetch_busy,
    output logic        underrun,
    input  logic        underrun_clr
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t      state, state_nx;
    logic        rb;
    logic [8:0]  vc    [2];
    logic [8:0]  vc_nx [2];
    logic [7:0]  i_q;
    logic [7:0]  sx, sy;
    logic [7:0]  tgt;
    logic        tgt_valid;
    logic [7:0]  lbuf  [2][256];

    logic        line_start, frame_start;
    logic [9:0]  n_line;
    logic        n_valid, swap, rb_eff, ack_wr, start_fetch;

    assign line_start  = (pix_x == 10'd0);
    assign frame_start = line_start && (pix_y == 10'd0);
    assign n_line      = (pix_y == 10'(V_TOTAL - 1)) ? 10'd0 : pix_y + 10'd1;
    assign n_valid     = (n_line < 10'(V_ACTIVE));
    assign start_fetch = line_start && n_valid;
    // The freshly fetched bank becomes visible on the very cycle its line begins,
    // so readout uses the post-swap bank select.
    assign swap        = line_start && tgt_valid && ({2'b00, tgt} == pix_y);
    assign rb_eff      = rb ^ swap;
    assign ack_wr      = (state == FETCH) && mem_ack;

    assign mem_req     = (state == FETCH);
    assign fetch_busy  = (state == FETCH);
    assign mem_addr    = {tgt + sy, i_q + sx};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_fetch) state_nx = FETCH;
            end
            FETCH: begin
                if (line_start)
                    state_nx = start_fetch ? FETCH : IDLE;
                else if (mem_ack && i_q == 8'hFF)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A coincident ack is counted in the old write bank before a new fetch clears
    // its own bank; when no swap happens both hit the same bank and the clear wins.
    always_comb begin
        vc_nx[0] = vc[0];
        vc_nx[1] = vc[1];
        if (ack_wr)
            vc_nx[~rb] = {1'b0, i_q} + 9'd1;
        if (start_fetch)
            vc_nx[~rb_eff] = 9'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rb        <= 1'b0;
            vc[0]     <= 9'd0;
            vc[1]     <= 9'd0;
            i_q       <= 8'd0;
            sx        <= 8'd0;
            sy        <= 8'd0;
            tgt       <= 8'd0;
            tgt_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state <= state_nx;
            vc[0] <= vc_nx[0];
            vc[1] <= vc_nx[1];
            if (line_start) begin
                rb        <= rb_eff;
                tgt_valid <= n_valid;
                if (n_valid)
                    tgt <= n_line[7:0];
            end
            if (frame_start) begin
                sx <= scroll_x;
                sy <= scroll_y;
            end
            if (start_fetch)
                i_q <= 8'd0;
            else if (ack_wr)
                i_q <= i_q + 8'd1;
            if (line_start && state == FETCH)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

    // Buffer contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (ack_wr)
            lbuf[~rb][i_q] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_data <= 8'h00;
        end else if (pix_x < 10'(H_ACTIVE) && pix_y < 10'(V_ACTIVE)) begin
            if (pix_x < {1'b0, vc[rb_eff]})
                pix_data <= lbuf[rb_eff][pix_x[7:0]];
            else
                pix_data <= FILL;
        end else begin
            pix_data <= 8'h00;
        end
    end

endmodule

// File: tb/tb_fc8_line_fetch.sv
// Self-checking bench for fc8_line_fetch: drives a timing generator and a VRAM
// responder, and predicts pixels and fetch addresses from a line-level model.
module tb_fc8_line_fetch;

    localparam int         HT   = 318;
    localparam int         VT   = 262;
    localparam logic [7:0] FILL = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  scroll_x, scroll_y;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_data;
    logic        fetch_busy;
    logic        underrun;
    logic        underrun_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the line being fetched, bytes delivered so far, and the line on screen.
    int          m_target;
    bit          m_active;
    int          m_cnt;
    logic [7:0]  m_fbuf [256];
    logic [7:0]  m_disp [256];
    int          m_disp_cnt;
    bit          m_ur;
    logic [7:0]  m_sx, m_sy;
    logic [7:0]  exp_pix;
    int          cyc = 0;
    int          ack_mode = 0;

    fc8_line_fetch #(
        .H_ACTIVE(256), .V_ACTIVE(240), .V_TOTAL(VT), .FILL(FILL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .scroll_x(scroll_x), .scroll_y(scroll_y),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pix_data(pix_data), .fetch_busy(fetch_busy), .underrun(underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] vram(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [15:0] model_addr();
        logic [7:0] row, col;
        row = 8'(m_target) + m_sy;
        col = 8'(m_cnt) + m_sx;
        return {row, col};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        m_target   = -1;
        m_active   = 1'b0;
        m_cnt      = 0;
        m_disp_cnt = 0;
        m_ur       = 1'b0;
        m_sx       = 8'h00;
        m_sy       = 8'h00;
        exp_pix    = 8'h00;
    endtask

    task automatic checkOutput();
        check("pix_data", 16'(pix_data), 16'(exp_pix));
        check("mem_req", 16'(mem_req), 16'(m_active));
        check("fetch_busy", 16'(fetch_busy), 16'(m_active));
        check("underrun", 16'(underrun), 16'(m_ur));
        if (m_active)
            check("mem_addr", mem_addr, model_addr());
    endtask

    // One pixel clock: check the previous edge's results, drive this cycle, advance the model.
    task automatic applyStimulus(input int x, input int y, input logic clr);
        bit was;
        int n;
        @(negedge clk);
        checkOutput();
        pix_x        = 10'(x);
        pix_y        = 10'(y);
        underrun_clr = clr;
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = cyc[0];
            2:       mem_ack = (($urandom % 10) != 0);
            default: mem_ack = (x == 0) || cyc[0];
        endcase
        mem_rdata = vram(mem_addr);
        cyc++;

        was = m_active;
        if (m_active && mem_ack) begin
            m_fbuf[m_cnt] = vram(model_addr());
            m_cnt++;
            if (m_cnt == 256)
                m_active = 1'b0;
        end
        if (x == 0) begin
            if (y == 0) begin
                m_sx = scroll_x;
                m_sy = scroll_y;
            end
            if (m_target == y) begin
                m_disp     = m_fbuf;
                m_disp_cnt = m_cnt;
            end
            n = (y == VT - 1) ? 0 : y + 1;
            if (n < 240) begin
                m_target = n;
                m_cnt    = 0;
                m_active = 1'b1;
            end else begin
                m_target = -1;
                m_active = 1'b0;
            end
        end
        if (x == 0 && was)
            m_ur = 1'b1;
        else if (clr)
            m_ur = 1'b0;
        if (x < 256 && y < 240)
            exp_pix = (x < m_disp_cnt) ? m_disp[x] : FILL;
        else
            exp_pix = 8'h00;
    endtask

    task automatic runLine(input int y);
        for (int x = 0; x < HT; x++)
            applyStimulus(x, y, 1'b0);
    endtask

    initial begin
        bit reached;
        rst_n        = 1'b0;
        pix_x        = 10'd1;
        pix_y        = 10'd250;
        scroll_x     = 8'h00;
        scroll_y     = 8'h00;
        mem_ack      = 1'b0;
        mem_rdata    = 8'h00;
        underrun_clr = 1'b0;
        modelReset();

        repeat (3) @(negedge clk);
        check("rst_pix_data", 16'(pix_data), 16'h0000);
        check("rst_mem_req", 16'(mem_req), 16'h0000);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_fetch_busy", 16'(fetch_busy), 16'h0000);
        check("rst_underrun", 16'(underrun), 16'h0000);
        rst_n = 1'b1;

        // Zero-wait frame start, including the fetch of row 0 from line 261.
        ack_mode = 0;
        applyStimulus(0, 261, 1'b0);
        @(posedge clk); #1;
        check("row0_req", 16'(mem_req), 16'h0001);
        check("row0_addr", mem_addr, 16'h0000);
        for (int x = 1; x < HT; x++)
            applyStimulus(x, 261, 1'b0);
        for (int y = 0; y < 6; y++)
            runLine(y);
        for (int y = 237; y < 242; y++)
            runLine(y);

        // Scroll 0x10/0xF8 latched at frame start; a mid-frame change must not apply.
        scroll_x = 8'h10;
        scroll_y = 8'hF8;
        runLine(261);
        for (int y = 0; y < 12; y++) begin
            if (y == 5) begin
                scroll_x = 8'($urandom);
                scroll_y = 8'($urandom);
            end
            if (y == 9) begin
                for (int x = 0; x < HT; x++) begin
                    applyStimulus(x, 9, 1'b0);
                    if (x == 0 || x == 239 || x == 240) begin
                        @(posedge clk); #1;
                        check("scroll_addr", mem_addr,
                              (x == 0) ? 16'h0210 : (x == 239) ? 16'h02FF : 16'h0200);
                    end
                end
            end else begin
                runLine(y);
            end
        end

        // Randomly throttled arbiter with random scroll for the next frame.
        ack_mode = 2;
        scroll_x = 8'($urandom);
        scroll_y = 8'($urandom);
        runLine(261);
        for (int y = 0; y < 4; y++)
            runLine(y);

        // Ack every second cycle: underrun, partial line, set beats clear, then clear.
        ack_mode = 1;
        runLine(20);
        runLine(21);
        applyStimulus(0, 22, 1'b1);
        @(posedge clk); #1;
        check("ur_set_beats_clr", 16'(underrun), 16'h0001);
        for (int x = 1; x < HT; x++) begin
            applyStimulus(x, 22, (x == 5));
            if (x == 5) begin
                @(posedge clk); #1;
                check("ur_cleared", 16'(underrun), 16'h0000);
            end
        end
        runLine(23);
        runLine(24);

        // Ack coincident with the line start while fetching.
        ack_mode = 3;
        runLine(40);
        applyStimulus(0, 41, 1'b0);
        @(posedge clk); #1;
        check("restart_req", 16'(mem_req), 16'h0001);
        check("restart_addr", mem_addr, {8'd42 + m_sy, m_sx});
        check("restart_ur", 16'(underrun), 16'h0001);
        for (int x = 1; x < HT; x++)
            applyStimulus(x, 41, 1'b0);
        runLine(42);

        // Asynchronous reset in the middle of a fetch at i = 100.
        ack_mode = 0;
        runLine(28);
        reached = 1'b0;
        for (int x = 0; x < HT && !reached; x++) begin
            applyStimulus(x, 29, 1'b0);
            if (m_cnt == 100 && m_active)
                reached = 1'b1;
        end
        if (!reached) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL wait_i100: observed no i=100 within line, required i=100");
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 16'(mem_req), 16'h0000);
        check("async_rst_busy", 16'(fetch_busy), 16'h0000);
        modelReset();
        @(negedge clk);
        check("async_rst_pix", 16'(pix_data), 16'h0000);
        check("async_rst_ur", 16'(underrun), 16'h0000);
        rst_n = 1'b1;
        runLine(30);
        runLine(31);
        runLine(32);
        @(negedge clk);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
